// File: rtl/tt_rts_rtr_elastic_buf_pkg.sv
// Shared helpers for the RTS/RTR elastic buffer and its pointer counters.
package tt_rts_rtr_elastic_buf_pkg;

  // Pointer width for a modulo-n counter; at least one bit even when n is tiny.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_rts_rtr_wrap_ctr.sv
// Modulo-N up-counter with synchronous clear; wraps from N-1 to 0 explicitly,
// so N does not have to be a power of two.
module tt_rts_rtr_wrap_ctr
  import tt_rts_rtr_elastic_buf_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned W = ptr_width(N)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (inc_i) begin
      value_d = (value_q == W'(N - 1)) ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/tt_rts_rtr_elastic_buf.sv
// Multi-entry RTS/RTR elastic buffer: flop-array FIFO whose o_rtr/o_rts come
// only from registered occupancy, with count, almost-full and flush.
module tt_rts_rtr_elastic_buf
  import tt_rts_rtr_elastic_buf_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned AFULL_THRESH = DEPTH - 1,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_rts,
  output logic             o_rtr,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_rts,
  input  logic             i_rtr,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_almost_full
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshake: a word moves when the sender's rts and the receiver's rtr are
  // both high at a rising edge; the sender keeps rts/data stable until then.
  // A flush cycle moves nothing on either side.
  assign o_rtr = (count_q != CW'(DEPTH));
  assign o_rts = (count_q != '0);
  assign push  = i_rts && o_rtr && !i_flush;
  assign pop   = o_rts && i_rtr && !i_flush;

  tt_rts_rtr_wrap_ctr #(.N(DEPTH)) u_wr_ptr (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .clear_i (i_flush),
    .inc_i   (push),
    .value_o (wr_ptr)
  );

  tt_rts_rtr_wrap_ctr #(.N(DEPTH)) u_rd_ptr (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .clear_i (i_flush),
    .inc_i   (pop),
    .value_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entries are cleared on reset so the head reads as zero until first written.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= i_data;
    end
  end

  assign o_data        = mem_q[rd_ptr];
  assign o_count       = count_q;
  assign o_almost_full = (count_q >= CW'(AFULL_THRESH));

  ap_out_hold: assert property (@(posedge i_clk) disable iff (i_reset)
    (o_rts && !i_rtr && !i_flush) |=> (o_rts && $stable(o_data)));

  ap_in_hold: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_rts && !o_rtr) |=> (i_rts && $stable(i_data)));

  ap_count_max: assert property (@(posedge i_clk) disable iff (i_reset)
    (count_q <= CW'(DEPTH)));

endmodule

// File: tb/tb_tt_rts_rtr_elastic_buf.sv
// Bench for tt_rts_rtr_elastic_buf: three instances (DEPTH 2, 3, 4; WIDTH 8)
// compared every cycle against queue models, plus directed literal checks.
module tb_tt_rts_rtr_elastic_buf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      rts_i, rtr_i, flush_i;
  logic [2:0][7:0] data_i;
  logic [2:0]      rts_o, rtr_o, af_o;
  logic [2:0][7:0] dat_o;
  logic [2:0][2:0] cnt_o;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned D  = 2 + g;
    localparam int unsigned CW = $clog2(D + 1);
    logic [CW-1:0] cnt;
    logic [7:0]    dat;
    logic          rts, rtr, af;

    tt_rts_rtr_elastic_buf #(.WIDTH(8), .DEPTH(D)) u_dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_flush       (flush_i[g]),
      .i_rts         (rts_i[g]),
      .o_rtr         (rtr),
      .i_data        (data_i[g]),
      .o_rts         (rts),
      .i_rtr         (rtr_i[g]),
      .o_data        (dat),
      .o_count       (cnt),
      .o_almost_full (af)
    );

    assign rts_o[g] = rts;
    assign rtr_o[g] = rtr;
    assign af_o[g]  = af;
    assign dat_o[g] = dat;
    assign cnt_o[g] = 3'(cnt);
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[3][$];
  bit   [2:0] acc_last;
  bit   [2:0] zero_known;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s depth=%0d got=%0h want=%0h t=%0t", name, k + 2, act, exp, $time);
    end
  endtask

  // Apply to the model what the coming rising edge must do.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int  dep;
      bit  push, pop;
      dep  = k + 2;
      push = 1'b0;
      pop  = 1'b0;
      if (rst) begin
        exp_q[k].delete();
        zero_known[k] = 1'b1;
      end else if (flush_i[k]) begin
        exp_q[k].delete();
      end else begin
        push = rts_i[k] && (exp_q[k].size() != dep);
        pop  = (exp_q[k].size() != 0) && rtr_i[k];
        if (pop)  void'(exp_q[k].pop_front());
        if (push) begin
          exp_q[k].push_back(data_i[k]);
          zero_known[k] = 1'b0;
        end
      end
      acc_last[k] = push;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int sz, dep;
      sz  = exp_q[k].size();
      dep = k + 2;
      chk("rts",   k, 32'(rts_o[k]), 32'(sz != 0));
      chk("rtr",   k, 32'(rtr_o[k]), 32'(sz != dep));
      chk("count", k, 32'(cnt_o[k]), 32'(sz));
      chk("afull", k, 32'(af_o[k]),  32'(sz >= dep - 1));
      if (sz != 0)             chk("data", k, 32'(dat_o[k]), 32'(exp_q[k][0]));
      else if (zero_known[k])  chk("data_zero", k, 32'(dat_o[k]), 32'h0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_all();
    rts_i = '0; rtr_i = '0; flush_i = '0; data_i = '0;
  endtask

  task automatic rand_phase(input int n, input int p_rts, input int p_rtr, input int p_fl);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!(rts_i[k] && !acc_last[k])) begin
          rts_i[k]  = ($urandom_range(0, 99) < p_rts);
          data_i[k] = 8'($urandom);
        end
        rtr_i[k]   = ($urandom_range(0, 99) < p_rtr);
        flush_i[k] = ($urandom_range(0, 99) < p_fl);
      end
      step();
    end
  endtask

  // Let pending words land, then drain everything.
  task automatic settle();
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (acc_last[k]) rts_i[k] = 1'b0;
        rtr_i[k]   = 1'b1;
        flush_i[k] = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int in_i, out_i, cyc;
    acc_last   = '0;
    zero_known = '0;
    rst = 1'b1;
    idle_all();
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk("reset_rts", k, 32'(rts_o[k]), 32'h0);
      chk("reset_rtr", k, 32'(rtr_o[k]), 32'h1);
      chk("reset_count", k, 32'(cnt_o[k]), 32'h0);
      chk("reset_data", k, 32'(dat_o[k]), 32'h0);
    end
    rst = 1'b0;
    step();

    // Fill then drain on DEPTH=4.
    for (int i = 0; i < 4; i++) begin
      rts_i[2] = 1'b1; data_i[2] = 8'(8'h11 + i);
      step();
      chk("fill_count", 2, 32'(cnt_o[2]), 32'(i + 1));
      chk("fill_afull", 2, 32'(af_o[2]), 32'(i + 1 >= 3));
    end
    rts_i[2] = 1'b0;
    chk("fill_rtr_low", 2, 32'(rtr_o[2]), 32'h0);
    step();
    chk("full_hold", 2, 32'(dat_o[2]), 32'h11);
    rtr_i[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 2, 32'(dat_o[2]), 32'(8'h11 + i));
      step();
    end
    chk("drain_count", 2, 32'(cnt_o[2]), 32'h0);
    rtr_i[2] = 1'b0;

    // Flush with count=3 and a push attempted in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      rts_i[2] = 1'b1; data_i[2] = 8'(8'h21 + i);
      step();
    end
    chk("pre_flush_count", 2, 32'(cnt_o[2]), 32'h3);
    flush_i[2] = 1'b1; data_i[2] = 8'hEE;
    step();
    chk("flush_count", 2, 32'(cnt_o[2]), 32'h0);
    chk("flush_rts", 2, 32'(rts_o[2]), 32'h0);
    chk("flush_rtr", 2, 32'(rtr_o[2]), 32'h1);
    flush_i[2] = 1'b0; rts_i[2] = 1'b0;
    step();
    chk("flush_no_ghost", 2, 32'(cnt_o[2]), 32'h0);
    rts_i[2] = 1'b1; data_i[2] = 8'h55;
    step();
    rts_i[2] = 1'b0; rtr_i[2] = 1'b1;
    chk("post_flush_head", 2, 32'(dat_o[2]), 32'h55);
    step();
    rtr_i[2] = 1'b0;

    // Streaming on DEPTH=2: 100 words, one per cycle after one cycle latency.
    in_i = 0; out_i = 0; cyc = 0;
    rtr_i[0] = 1'b1;
    while (out_i < 100 && cyc < 300) begin
      if (rts_i[0] && acc_last[0]) in_i++;
      if (rts_o[0]) begin
        chk("stream_data", 0, 32'(dat_o[0]), 32'(out_i[7:0]));
        out_i++;
      end
      chk("stream_rtr", 0, 32'(rtr_o[0]), 32'h1);
      rts_i[0]  = (in_i < 100);
      data_i[0] = 8'(in_i);
      cyc++;
      step();
    end
    chk("stream_outputs", 0, 32'(out_i), 32'd100);
    chk("stream_cycles", 0, 32'(cyc), 32'd101);
    rts_i[0] = 1'b0; rtr_i[0] = 1'b0;
    step();

    // Full with simultaneous pop on DEPTH=2.
    rts_i[0] = 1'b1; data_i[0] = 8'hA0;
    step();
    data_i[0] = 8'hA1;
    step();
    chk("full_count", 0, 32'(cnt_o[0]), 32'h2);
    chk("full_rtr", 0, 32'(rtr_o[0]), 32'h0);
    data_i[0] = 8'hB0; rtr_i[0] = 1'b1;
    step();
    chk("fullpop_count", 0, 32'(cnt_o[0]), 32'h1);
    chk("fullpop_rtr", 0, 32'(rtr_o[0]), 32'h1);
    chk("fullpop_head", 0, 32'(dat_o[0]), 32'hA1);
    step();
    chk("refill_count", 0, 32'(cnt_o[0]), 32'h1);
    chk("refill_head", 0, 32'(dat_o[0]), 32'hB0);
    rts_i[0] = 1'b0;
    step();
    rtr_i[0] = 1'b0;

    // Non-power-of-2 wrap on DEPTH=3: 10 words with random back-pressure.
    in_i = 0; out_i = 0; cyc = 0;
    while (out_i < 10 && cyc < 200) begin
      if (rts_i[1] && acc_last[1]) in_i++;
      rtr_i[1] = ($urandom_range(0, 99) < 45);
      if (rts_o[1] && rtr_i[1]) begin
        chk("wrap_data", 1, 32'(dat_o[1]), 32'(8'h30 + out_i));
        out_i++;
      end
      rts_i[1]  = (in_i < 10);
      data_i[1] = 8'(8'h30 + in_i);
      cyc++;
      step();
    end
    chk("wrap_outputs", 1, 32'(out_i), 32'd10);
    idle_all();
    step();

    // Random traffic on all three instances.
    rand_phase(500, 70, 80, 2);
    settle();
    rand_phase(500, 80, 30, 1);

    // Reset mid-stream.
    rst = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("midrst_rts", k, 32'(rts_o[k]), 32'h0);
      chk("midrst_rtr", k, 32'(rtr_o[k]), 32'h1);
      chk("midrst_count", k, 32'(cnt_o[k]), 32'h0);
      chk("midrst_data", k, 32'(dat_o[k]), 32'h0);
      chk("midrst_afull", k, 32'(af_o[k]), 32'h0);
    end
    rst = 1'b0;
    idle_all();
    step();
    rand_phase(300, 60, 60, 2);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_rts_rtr_elastic_buf.md
# tt_rts_rtr_elastic_buf

Parametrised multi-entry RTS/RTR elastic buffer, the next-generation replacement for the single-entry RTS/RTR pipe stage. Breaks the combinational `i_rtr` → `o_rtr` path: `o_rtr` depends only on registered state. Sustains one transfer per cycle in steady state. Adds occupancy reporting, an almost-full watermark and a synchronous flush. Used on vector-unit datapaths where back-pressure must be registered at block boundaries.

## Interface
- `WIDTH`, 1: payload width in bits.
- `DEPTH`, 2: number of entries; legal range ≥2; need not be a power of two.
- `AFULL_THRESH`, DEPTH-1: `o_almost_full` asserts when count ≥ this value; legal range 1..DEPTH.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_flush` input 1: synchronous discard of all stored entries.
- `i_rts` input 1: upstream has valid data.
- `o_rtr` output 1: buffer can accept; registered-state only, no combinational input dependency.
- `i_data` input WIDTH: upstream payload.
- `o_rts` output 1: buffer head is valid.
- `i_rtr` input 1: downstream accepts the head.
- `o_data` output WIDTH: head payload.
- `o_count` output $clog2(DEPTH+1): current occupancy.
- `o_almost_full` output 1: count ≥ AFULL_THRESH.

## Operation
- Storage: circular array of DEPTH entries with write pointer `wr_ptr`, read pointer `rd_ptr` and counter `count`.
- Push: `i_rts & o_rtr & !i_flush`. Writes `i_data` to `mem[wr_ptr]` and advances `wr_ptr`.
- Pop: `o_rts & i_rtr & !i_flush`. Advances `rd_ptr`.
- Pointer wrap: pointers increment modulo DEPTH. Explicit compare at DEPTH-1 → 0; no reliance on power-of-2 overflow.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, including when count=1.
- `o_rtr` = (count != DEPTH).
  - When full, no push occurs even if a pop happens that cycle.
  - `o_rtr` reasserts the cycle after the pop.
- `o_rts` = (count != 0).
- `o_data` = `mem[rd_ptr]`.
- No bypass: data written in cycle N is first visible on `o_data` in cycle N+1.
- Flush:
  - `i_flush=1` sets count, `wr_ptr` and `rd_ptr` to 0.
  - Any push or pop attempted that cycle is discarded; `o_rts` and `o_rtr` as seen that cycle are not honoured as transfers.
  - Flush has priority over push and pop; reset has priority over flush.
- Reset values:
  - `o_rts`=0, `o_rtr`=1, `o_count`=0, `o_almost_full`=0.
  - `o_data`=0: all entries cleared to 0 on reset.
  - Reset mid-operation drops all entries without any output transfer.
- Handshake rules:
  - Upstream must hold `i_rts` and `i_data` stable until accepted.
  - This block holds `o_rts` and `o_data` stable until `i_rtr`, except across flush or reset.

## Timing
- Latency: 1 cycle from accept to `o_rts`.
- Throughput: 1 transfer per cycle with continuous `i_rts` and `i_rtr`, at any count between 1 and DEPTH-1.
- Full buffer with continuous `i_rtr` sustains 1 transfer per cycle after one refill cycle.
  - The pop cycle is not accompanied by a push.
  - Next cycle count = DEPTH-1 and `o_rtr`=1.
  - From then, push and pop are simultaneous each cycle.
- `o_count` and `o_almost_full` are registered-state-derived and track count the same cycle it updates.
- SIM-only assertions:
  - `o_rts` high and `i_rtr` low ⇒ next cycle `o_rts` high and `o_data` unchanged, unless flush or reset.
  - `i_rts` high and `o_rtr` low ⇒ next cycle `i_rts` high and `i_data` unchanged.
  - Count never exceeds DEPTH.

## Structure
- No shared package types needed; count and pointer widths are local parameters derived from DEPTH.
- One sub-module: `tt_rts_rtr_wrap_ctr`, a modulo-N up-counter with increment and clear, instanced for `wr_ptr` and `rd_ptr`.
- Storage is a flop array, no SRAM macro.

## Test plan
- **Fill then drain.** DEPTH=4, WIDTH=8, `i_rtr`=0, push 0x11..0x14.
  - `o_rtr` drops after the 4th accept; count=4; `o_almost_full` from count 3.
  - Release `i_rtr` → 0x11..0x14 out in order; count returns to 0.
- **Streaming.** DEPTH=2, continuous `i_rts` and `i_rtr`, 100 incrementing words → 100 in-order outputs, one per cycle after the first-cycle latency.
- **Non-power-of-2 wrap.** DEPTH=3, 10 pushes interleaved with random `i_rtr` → no loss or duplication; pointers wrap 2→0.
- **Full with simultaneous pop.** DEPTH=2, full, `i_rtr`=1 and `i_rts`=1.
  - That cycle: pop only, count 2→1.
  - Next cycle: push and pop together, count stays 1.
- **Flush.** Flush with count=3 and push attempted that cycle → next cycle count=0, `o_rts`=0, `o_rtr`=1; the attempted word never appears.
- **Reset mid-stream.** Reset asserted mid-stream → next cycle `o_rts`=0, `o_data`=0, `o_count`=0, `o_rtr`=1.
